pixel_compositor: RTL and testbench
===================================

PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of sprite layers; index 0 is highest priority.
REQ-002 SHALL have parameter HOLD_FRAMES, default 8, number of frames held fully black between fade-out and fade-in.
REQ-003 SHALL have port clk, input, 1 bit, system clock; there is one clock only.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port pix_en, input, 1 bit, pixel-rate enable; the pipeline advances only when it is high.
REQ-006 SHALL have ports in_hsync, in_vsync and in_de, input, 1 bit each, timing from the VGA timing generator.
REQ-007 SHALL have port layer_rgb, input, NUM_LAYERS x 24 bits (rgb_t array), layer colours; TRANSPARENT means no pixel on that layer.
REQ-008 SHALL have port bg_rgb, input, 24 bits (rgb_t), background colour (sky/ground renderer).
REQ-009 SHALL have port fade_start, input, 1 bit, single-cycle request to start a fade-out/hold/fade-in sequence.
REQ-010 SHALL have port fade_busy, output, 1 bit, high while the fade sequence is not IDLE.
REQ-011 SHALL have port out_rgb, output, 24 bits (rgb_t), final pixel colour.
REQ-012 SHALL have ports out_hsync, out_vsync and out_de, output, 1 bit each, timing aligned with out_rgb.

Function
REQ-013 Stage 1 SHALL select the lowest-index layer whose value is not TRANSPARENT; if all layers are transparent, it SHALL select bg_rgb.
REQ-014 Stage 2 SHALL scale each colour channel: out = (ch * level) >> 4, with level in 0..16.
- Each product is 13 bits.
- level 16 passes the channel unchanged; level 0 gives 0.
REQ-015 When the stage-2 de is 0, out_rgb SHALL be BLACK regardless of layer inputs.
REQ-016 Latency SHALL be exactly 2 pix_en cycles from inputs to outputs.
- hsync, vsync and de SHALL be delayed identically to the colour.
- When pix_en=0, all pipeline registers SHALL hold their values.
REQ-017 The frame tick SHALL be an in_vsync 0->1 transition, sampled on pix_en cycles.
REQ-018 The fade FSM SHALL have the states IDLE, FADE_OUT, HOLD and FADE_IN.
- IDLE: level=16.
- IDLE -> FADE_OUT when fade_start=1.
- FADE_OUT: level decrements by 1 per frame tick; at level 0, go to HOLD.
- HOLD: count HOLD_FRAMES frame ticks, then go to FADE_IN.
- FADE_IN: level increments by 1 per frame tick; at level 16, go to IDLE.
REQ-019 level SHALL change only on a frame tick, so there is no mid-frame tearing.
REQ-020 fade_start SHALL be ignored when the FSM is not IDLE.
REQ-021 fade_start arriving together with a frame tick in IDLE SHALL enter FADE_OUT; the first decrement happens on the next frame tick.
REQ-022 level SHALL never underflow below 0 or overflow above 16.

Reset
REQ-023 On rst_n low, all of the following SHALL apply asynchronously, including mid-fade:
- out_rgb=BLACK; out_hsync, out_vsync, out_de=0.
- FSM=IDLE, level=16, hold counter=0, fade_busy=0.
- pipeline cleared, vsync edge detector cleared.

Configuration
REQ-024 With COMPOSITOR_FADE_EN defined, the fade FSM and the stage-2 scaling SHALL be present.
REQ-025 Without COMPOSITOR_FADE_EN:
- stage 2 SHALL register the colour unscaled;
- fade_start SHALL be ignored and fade_busy tied to 0;
- latency SHALL remain 2.

Structure
REQ-026 color_pkg SHALL hold rgb_t, TRANSPARENT, BLACK, a new fade_state_t enum and FADE_LEVEL_MAX=16.
REQ-027 The fade FSM, level register and hold counter SHALL live in the sub-module compositor_fade_ctrl, which outputs level[4:0] and fade_busy.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Priority: layer0=TRANSPARENT, layer1=IC_RED, layer2=BOX_YELLOW, de=1 -> out_rgb=FF0000 two pix_en cycles later.
- All layers TRANSPARENT, bg=SKY_BLUE -> 5DADE2; then de=0 -> 000000; syncs delayed by exactly 2 pix_en cycles.
- pix_en toggling 1,0,0,1 -> outputs change only on enabled cycles; latency counted in enabled cycles.
- fade_start, HOLD_FRAMES=2:
  - level 16..0 over 16 frames, WHITE scaled to 000000;
  - hold 2 frames;
  - back to FFFFFF after 16 more frames;
  - fade_busy high throughout, and a second fade_start mid-sequence is ignored.
- Level 8 with DIRT_MID (8B653F) -> 45321F.
- rst_n pulsed low at level 5 in FADE_OUT -> fade_busy=0, out_rgb=000000 immediately; the next frame passes colours unscaled.
- Build without COMPOSITOR_FADE_EN, then fade_start -> fade_busy stays 0 and colours are unchanged.

Source files
------------

// File: rtl/color_pkg.sv
// Shared colour types, sentinel colours and fade-controller definitions
// for the pixel compositor.
package color_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      IDLE,
      FADE_OUT,
      HOLD,
      FADE_IN
   } fade_state_t;

   // Magenta is reserved as the "no pixel here" key colour on sprite layers.
   localparam rgb_t TRANSPARENT = 24'hFF00FF;
   localparam rgb_t BLACK       = 24'h000000;

   localparam logic [4:0] FADE_LEVEL_MAX = 5'd16;

   function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [4:0] lvl);
      logic [12:0] p;
      p = 13'(ch) * 13'(lvl);
      return 8'(p >> 4);
   endfunction

   function automatic rgb_t scale_rgb(input rgb_t c, input logic [4:0] lvl);
      rgb_t s;
      s.r = scale_ch(c.r, lvl);
      s.g = scale_ch(c.g, lvl);
      s.b = scale_ch(c.b, lvl);
      return s;
   endfunction

endpackage

// File: rtl/compositor_fade_ctrl.sv
// Fade-out / hold / fade-in sequencer. The brightness level only moves on a
// frame tick (rising edge of vsync seen on a pixel-enable cycle).
module compositor_fade_ctrl
   import color_pkg::*;
#(
   parameter int HOLD_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   input  logic       vsync,
   input  logic       fade_start,
   output logic [4:0] level,
   output logic       fade_busy
);

   localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

   fade_state_t   r_state;
   logic [4:0]    r_level;
   logic [HW-1:0] r_hold;
   logic          r_vs_d;
   logic          r_busy;
   logic          w_tick;

   assign w_tick    = pix_en & vsync & ~r_vs_d;
   assign level     = r_level;
   assign fade_busy = r_busy;

   // A start request coinciding with a tick only arms the sequence; the
   // first decrement waits for the following tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_level <= FADE_LEVEL_MAX;
         r_hold  <= '0;
         r_vs_d  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         if (pix_en)
            r_vs_d <= vsync;
         case (r_state)
            IDLE: begin
               r_level <= FADE_LEVEL_MAX;
               if (fade_start) begin
                  r_state <= FADE_OUT;
                  r_busy  <= 1'b1;
               end
            end
            FADE_OUT: begin
               if (w_tick && r_level != 5'd0) begin
                  r_level <= r_level - 5'd1;
                  if (r_level == 5'd1) begin
                     r_state <= HOLD;
                     r_hold  <= '0;
                  end
               end
            end
            HOLD: begin
               if (w_tick) begin
                  if (r_hold == HW'(HOLD_FRAMES - 1)) begin
                     r_state <= FADE_IN;
                     r_hold  <= '0;
                  end else begin
                     r_hold <= r_hold + 1'b1;
                  end
               end
            end
            FADE_IN: begin
               if (w_tick && r_level != FADE_LEVEL_MAX) begin
                  r_level <= r_level + 5'd1;
                  if (r_level == FADE_LEVEL_MAX - 5'd1) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage sprite compositor: stage 1 picks the top visible layer, stage 2
// applies the fade level and blanking. Fade is built only with COMPOSITOR_FADE_EN.
module pixel_compositor
   import color_pkg::*;
#(
   parameter int NUM_LAYERS  = 4,
   parameter int HOLD_FRAMES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pix_en,
   input  logic                  in_hsync,
   input  logic                  in_vsync,
   input  logic                  in_de,
   input  rgb_t [NUM_LAYERS-1:0] layer_rgb,
   input  rgb_t                  bg_rgb,
   input  logic                  fade_start,
   output logic                  fade_busy,
   output rgb_t                  out_rgb,
   output logic                  out_hsync,
   output logic                  out_vsync,
   output logic                  out_de
);

   rgb_t w_sel;
   rgb_t w_scaled;
   rgb_t r1_rgb;
   logic r1_hs, r1_vs, r1_de;
   rgb_t r2_rgb;
   logic r2_hs, r2_vs, r2_de;

   // Walk from the lowest priority upward so layer 0 overwrites everything.
   always_comb begin
      w_sel = bg_rgb;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_rgb[i] != TRANSPARENT)
            w_sel = layer_rgb[i];
      end
   end

`ifdef COMPOSITOR_FADE_EN
   logic [4:0] w_level;

   compositor_fade_ctrl #(
      .HOLD_FRAMES (HOLD_FRAMES)
   ) u_fade_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_en     (pix_en),
      .vsync      (in_vsync),
      .fade_start (fade_start),
      .level      (w_level),
      .fade_busy  (fade_busy)
   );

   assign w_scaled = scale_rgb(r1_rgb, w_level);
`else
   logic w_unused;

   assign w_unused  = fade_start;
   assign fade_busy = 1'b0;
   assign w_scaled  = r1_rgb;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_rgb <= BLACK;
         r1_hs  <= 1'b0;
         r1_vs  <= 1'b0;
         r1_de  <= 1'b0;
         r2_rgb <= BLACK;
         r2_hs  <= 1'b0;
         r2_vs  <= 1'b0;
         r2_de  <= 1'b0;
      end else if (pix_en) begin
         r1_rgb <= w_sel;
         r1_hs  <= in_hsync;
         r1_vs  <= in_vsync;
         r1_de  <= in_de;
         r2_rgb <= r1_de ? w_scaled : BLACK;
         r2_hs  <= r1_hs;
         r2_vs  <= r1_vs;
         r2_de  <= r1_de;
      end
   end

   assign out_rgb   = r2_rgb;
   assign out_hsync = r2_hs;
   assign out_vsync = r2_vs;
   assign out_de    = r2_de;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor; the fade sequence is exercised when
// built with COMPOSITOR_FADE_EN, otherwise the fade-disabled behaviour is checked.
module tb_pixel_compositor;
   import color_pkg::*;

   localparam rgb_t IC_RED     = 24'hFF0000;
   localparam rgb_t BOX_YELLOW = 24'hFFD700;
   localparam rgb_t SKY_BLUE   = 24'h5DADE2;
   localparam rgb_t DIRT_MID   = 24'h8B653F;
   localparam rgb_t WHITE      = 24'hFFFFFF;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            pix_en;
   logic            in_hsync, in_vsync, in_de;
   rgb_t [3:0]      layer_rgb;
   rgb_t            bg_rgb;
   logic            fade_start;
   logic            fade_busy;
   rgb_t            out_rgb;
   logic            out_hsync, out_vsync, out_de;

   int checks = 0;
   int errors = 0;

   pixel_compositor #(
      .NUM_LAYERS  (4),
      .HOLD_FRAMES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_en     (pix_en),
      .in_hsync   (in_hsync),
      .in_vsync   (in_vsync),
      .in_de      (in_de),
      .layer_rgb  (layer_rgb),
      .bg_rgb     (bg_rgb),
      .fade_start (fade_start),
      .fade_busy  (fade_busy),
      .out_rgb    (out_rgb),
      .out_hsync  (out_hsync),
      .out_vsync  (out_vsync),
      .out_de     (out_de)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic frameTick();
      in_vsync = 1'b1;
      step();
      in_vsync = 1'b0;
      step();
   endtask

   function automatic logic [23:0] whiteAt(input int lvl);
      logic [7:0] c;
      c = 8'((255 * lvl) >> 4);
      return {c, c, c};
   endfunction

   initial begin
      rst_n      = 1'b0;
      pix_en     = 1'b1;
      in_hsync   = 1'b0;
      in_vsync   = 1'b0;
      in_de      = 1'b0;
      layer_rgb  = {TRANSPARENT, TRANSPARENT, TRANSPARENT, TRANSPARENT};
      bg_rgb     = BLACK;
      fade_start = 1'b0;
      #12;
      checkOutput("reset_rgb", out_rgb, 24'h000000);
      checkOutput("reset_syncs", {21'd0, out_hsync, out_vsync, out_de}, 24'd0);
      checkOutput("reset_busy", {23'd0, fade_busy}, 24'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Priority: layer 0 transparent, layer 1 wins over layer 2
      layer_rgb = {TRANSPARENT, BOX_YELLOW, IC_RED, TRANSPARENT};
      in_de = 1'b1;
      step();
      checkOutput("prio_lat1", out_rgb, 24'h000000);
      step();
      checkOutput("prio_lat2", out_rgb, 24'hFF0000);

      // All transparent: background shows through
      layer_rgb = {TRANSPARENT, TRANSPARENT, TRANSPARENT, TRANSPARENT};
      bg_rgb = SKY_BLUE;
      step();
      step();
      checkOutput("bg_sky", out_rgb, 24'h5DADE2);
      in_de = 1'b0;
      step();
      checkOutput("blank_lat1", out_rgb, 24'h5DADE2);
      step();
      checkOutput("blank_de0", out_rgb, 24'h000000);

      // Sync pass-through delayed by two enabled cycles
      in_hsync = 1'b1;
      in_vsync = 1'b1;
      step();
      checkOutput("sync_lat1", {22'd0, out_hsync, out_vsync}, 24'd0);
      step();
      checkOutput("sync_lat2", {22'd0, out_hsync, out_vsync}, 24'd3);
      in_hsync = 1'b0;
      in_vsync = 1'b0;
      step();
      checkOutput("sync_fall1", {22'd0, out_hsync, out_vsync}, 24'd3);
      step();
      checkOutput("sync_fall2", {22'd0, out_hsync, out_vsync}, 24'd0);

      // pix_en 1,0,0,1: output only advances on enabled cycles
      in_de = 1'b1;
      step();
      step();
      checkOutput("en_base", out_rgb, 24'h5DADE2);
      layer_rgb[0] = DIRT_MID;
      step();
      checkOutput("en_cyc1", out_rgb, 24'h5DADE2);
      pix_en = 1'b0;
      layer_rgb[0] = IC_RED;
      step();
      checkOutput("en_cyc2", out_rgb, 24'h5DADE2);
      step();
      checkOutput("en_cyc3", out_rgb, 24'h5DADE2);
      pix_en = 1'b1;
      step();
      checkOutput("en_cyc4", out_rgb, 24'h8B653F);
      step();
      checkOutput("en_cyc5", out_rgb, 24'hFF0000);

      layer_rgb[0] = WHITE;
      step();
      step();
      checkOutput("white_base", out_rgb, 24'hFFFFFF);

`ifdef COMPOSITOR_FADE_EN
      // Start request coinciding with a frame tick only arms the fade
      fade_start = 1'b1;
      in_vsync = 1'b1;
      step();
      fade_start = 1'b0;
      in_vsync = 1'b0;
      step();
      step();
      checkOutput("fade_armed_busy", {23'd0, fade_busy}, 24'd1);
      checkOutput("fade_armed_lvl16", out_rgb, whiteAt(16));

      for (int k = 1; k <= 16; k++) begin
         if (k == 4) begin
            fade_start = 1'b1;
            step();
            fade_start = 1'b0;
         end
         frameTick();
         step();
         checkOutput($sformatf("fadeout_lvl%0d", 16 - k), out_rgb, whiteAt(16 - k));
         checkOutput($sformatf("fadeout_busy%0d", 16 - k), {23'd0, fade_busy}, 24'd1);
         if (k == 8) begin
            layer_rgb[0] = DIRT_MID;
            step();
            step();
            checkOutput("dirt_lvl8", out_rgb, 24'h45321F);
            layer_rgb[0] = WHITE;
            step();
            step();
         end
      end

      for (int h = 1; h <= 2; h++) begin
         frameTick();
         step();
         checkOutput($sformatf("hold_%0d", h), out_rgb, 24'h000000);
         checkOutput($sformatf("hold_busy%0d", h), {23'd0, fade_busy}, 24'd1);
      end

      for (int k = 1; k <= 16; k++) begin
         frameTick();
         step();
         checkOutput($sformatf("fadein_lvl%0d", k), out_rgb, whiteAt(k));
         checkOutput($sformatf("fadein_busy%0d", k), {23'd0, fade_busy}, (k == 16) ? 24'd0 : 24'd1);
      end

      frameTick();
      step();
      checkOutput("idle_stays_full", out_rgb, 24'hFFFFFF);

      // Reset in the middle of FADE_OUT at level 5
      fade_start = 1'b1;
      step();
      fade_start = 1'b0;
      for (int k = 1; k <= 11; k++)
         frameTick();
      step();
      checkOutput("pre_reset_lvl5", out_rgb, 24'h4F4F4F);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_busy", {23'd0, fade_busy}, 24'd0);
      checkOutput("async_rst_rgb", out_rgb, 24'h000000);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      checkOutput("post_rst_full", out_rgb, 24'hFFFFFF);
      frameTick();
      step();
      checkOutput("post_rst_frame", out_rgb, 24'hFFFFFF);
      checkOutput("post_rst_busy", {23'd0, fade_busy}, 24'd0);
`else
      fade_start = 1'b1;
      step();
      fade_start = 1'b0;
      checkOutput("nofade_busy0", {23'd0, fade_busy}, 24'd0);
      for (int k = 1; k <= 3; k++) begin
         frameTick();
         step();
         checkOutput($sformatf("nofade_rgb%0d", k), out_rgb, 24'hFFFFFF);
         checkOutput($sformatf("nofade_busy%0d", k), {23'd0, fade_busy}, 24'd0);
      end
      layer_rgb[0] = DIRT_MID;
      step();
      step();
      checkOutput("nofade_dirt", out_rgb, 24'h8B653F);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
